// File: rtl/parse_pkt_disp_mc.sv
// Multi-channel packet dispatcher: buffers head, payload and metadata words,
// then steers each packet to one of CH channels or discards it.
// Ports: clk, reset (async, active-low); pkt_head/payload/metadata writes;
// per-channel out_data/out_md with strobes; out_usedw per-channel fill level;
// buf_addr_full upstream backpressure; stat_pkts/stat_drops counters.
// Build macro: PKT_DISP_STAT_EN enables the statistics counters.

module parse_pkt_disp_mc_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wrreq,
   input  logic [W-1:0]  data,
   input  logic          rdreq,
   output logic [W-1:0]  q,
   output logic          empty,
   output logic [AW:0]   usedw
);
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          wr;
   logic          rd;

   assign empty = (usedw == '0);
   assign wr    = wrreq && (usedw != DEPTH);
   assign rd    = rdreq && !empty;
   // show-ahead: head word is visible without a read request
   assign q     = mem[rp];

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         usedw <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         case ({wr, rd})
            2'b10:   usedw <= usedw + 1'b1;
            2'b01:   usedw <= usedw - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module parse_pkt_disp_mc #(
   parameter int DW      = 139,
   parameter int MW      = 360,
   parameter int CH      = 4,
   parameter int SEL_LSB = 348,
   parameter int FIFO_AW = 8,
   parameter int MD_AW   = 4,
   parameter int OUT_THR = 161,
   parameter int IN_THR  = 160
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pkt_head_valid,
   input  logic [DW-1:0]     pkt_head,
   input  logic              pkt_payload_valid,
   input  logic [DW-1:0]     pkt_payload,
   input  logic              pkt_metadata_valid,
   input  logic [MW-1:0]     pkt_metadata,
   output logic [CH-1:0]     out_data_valid,
   output logic [CH*DW-1:0]  out_data,
   output logic [CH-1:0]     out_md_valid,
   output logic [CH*MW-1:0]  out_md,
   input  logic [CH*8-1:0]   out_usedw,
   output logic              buf_addr_full,
   output logic [CH*32-1:0]  stat_pkts,
   output logic [31:0]       stat_drops
);
   localparam int SELW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [2:0] TAG_M = 3'b100;
   localparam logic [2:0] TAG_L = 3'b110;
   localparam logic [SELW:0]    CH_W  = (SELW+1)'(CH);
   localparam logic [8:0]       OUT_T = 9'(OUT_THR);
   localparam logic [FIFO_AW:0] IN_T  = (FIFO_AW+1)'(IN_THR);
   localparam logic [MD_AW:0]   MD_T  = (MD_AW+1)'(2**MD_AW - 3);

   typedef enum logic [2:0] {
      IDLE, PARSE, DISCARD, TRANS_H, TRANS_B
   } state_t;

   state_t state;
   state_t nxt;

   logic [DW-1:0]    h_q;
   logic [DW-1:0]    p_q;
   logic [MW-1:0]    m_q;
   logic             h_empty;
   logic             p_empty;
   logic             m_empty;
   logic [FIFO_AW:0] h_used;
   logic [FIFO_AW:0] p_used;
   logic [MD_AW:0]   m_used;
   logic             h_pop;
   logic             p_pop;
   logic             m_pop;

   logic [MW-1:0]   md_r;
   logic [SELW-1:0] sel;
   logic [7:0]      usel;
   logic            sel_bad;
   logic            o_vld;
   logic            o_md;
   logic [DW-1:0]   o_word;

   logic [CH-1:0][DW-1:0] data_r;
   logic [CH-1:0][MW-1:0] mdo_r;
   logic [CH-1:0]         dv;
   logic [CH-1:0]         mv;

   parse_pkt_disp_mc_fifo #(.W(DW), .AW(FIFO_AW)) u_head (
      .clk(clk), .reset(reset),
      .wrreq(pkt_head_valid), .data(pkt_head),
      .rdreq(h_pop), .q(h_q), .empty(h_empty), .usedw(h_used)
   );

   parse_pkt_disp_mc_fifo #(.W(DW), .AW(FIFO_AW)) u_pay (
      .clk(clk), .reset(reset),
      .wrreq(pkt_payload_valid), .data(pkt_payload),
      .rdreq(p_pop), .q(p_q), .empty(p_empty), .usedw(p_used)
   );

   parse_pkt_disp_mc_fifo #(.W(MW), .AW(MD_AW)) u_md (
      .clk(clk), .reset(reset),
      .wrreq(pkt_metadata_valid), .data(pkt_metadata),
      .rdreq(m_pop), .q(m_q), .empty(m_empty), .usedw(m_used)
   );

   assign sel     = md_r[SEL_LSB +: SELW];
   assign sel_bad = {1'b0, sel} >= CH_W;

   // mux keeps the usedw lookup in range for non-power-of-two CH
   always_comb begin
      usel = '0;
      for (int i = 0; i < CH; i++) begin
         if (sel == SELW'(i)) usel = out_usedw[i*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt    = state;
      h_pop  = 1'b0;
      p_pop  = 1'b0;
      m_pop  = 1'b0;
      o_vld  = 1'b0;
      o_md   = 1'b0;
      o_word = h_q;
      unique case (state)
         IDLE: begin
            if (!m_empty) begin
               m_pop = 1'b1;
               nxt   = PARSE;
            end
         end
         PARSE: begin
            if (md_r[MW-1] || sel_bad)
               nxt = DISCARD;
            else if ({1'b0, usel} < OUT_T)
               nxt = TRANS_H;
         end
         DISCARD: begin
            if (!h_empty) begin
               h_pop = 1'b1;
               if (h_q[DW-1 -: 3] == TAG_L) nxt = IDLE;
            end
         end
         TRANS_H: begin
            if (!h_empty) begin
               h_pop = 1'b1;
               o_vld = 1'b1;
               if (h_q[DW-1 -: 3] == TAG_L) begin
                  if (md_r[MW-4]) begin
                     o_md = 1'b1;
                     nxt  = IDLE;
                  end else begin
                     // body follows, so the head no longer ends the frame
                     o_word[DW-1 -: 3] = TAG_M;
                     nxt = TRANS_B;
                  end
               end
            end
         end
         TRANS_B: begin
            o_word = p_q;
            if (!p_empty) begin
               p_pop = 1'b1;
               o_vld = 1'b1;
               if (p_q[DW-1 -: 3] == TAG_L) begin
                  o_md = 1'b1;
                  nxt  = IDLE;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) md_r <= '0;
      else if (state == IDLE && !m_empty) md_r <= m_q;
   end

   // only the selected channel updates; the others hold their buses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dv     <= '0;
         mv     <= '0;
         data_r <= '0;
         mdo_r  <= '0;
      end else begin
         dv <= '0;
         mv <= '0;
         for (int i = 0; i < CH; i++) begin
            if (sel == SELW'(i)) begin
               if (o_vld) begin
                  dv[i]     <= 1'b1;
                  data_r[i] <= o_word;
               end
               if (o_md) begin
                  mv[i]    <= 1'b1;
                  mdo_r[i] <= md_r;
               end
            end
         end
      end
   end

   assign out_data_valid = dv;
   assign out_md_valid   = mv;
   assign out_data       = data_r;
   assign out_md         = mdo_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) buf_addr_full <= 1'b0;
      else buf_addr_full <= (h_used >= IN_T) || (p_used >= IN_T) ||
                            (m_used >= MD_T);
   end

`ifdef PKT_DISP_STAT_EN
   logic [CH-1:0][31:0] pk_r;
   logic [31:0]         dr_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pk_r <= '0;
         dr_r <= '0;
      end else begin
         if (state == PARSE && nxt == DISCARD) dr_r <= dr_r + 1'b1;
         for (int i = 0; i < CH; i++) begin
            if (o_md && sel == SELW'(i)) pk_r[i] <= pk_r[i] + 1'b1;
         end
      end
   end

   assign stat_pkts  = pk_r;
   assign stat_drops = dr_r;
`else
   assign stat_pkts  = '0;
   assign stat_drops = '0;
`endif
endmodule

// File: tb/tb_parse_pkt_disp_mc.sv
// Scoreboard bench for parse_pkt_disp_mc: directed packets, a queue of
// expected channel words, and a monitor comparing every strobe.

module tb_parse_pkt_disp_mc;
   localparam int DW = 139;
   localparam int MW = 360;
   localparam int CH = 4;

   typedef struct {
      int            ch;
      logic [DW-1:0] w;
      bit            md;
      logic [MW-1:0] m;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              pkt_head_valid = 1'b0;
   logic [DW-1:0]     pkt_head = '0;
   logic              pkt_payload_valid = 1'b0;
   logic [DW-1:0]     pkt_payload = '0;
   logic              pkt_metadata_valid = 1'b0;
   logic [MW-1:0]     pkt_metadata = '0;
   logic [CH-1:0]     out_data_valid;
   logic [CH*DW-1:0]  out_data;
   logic [CH-1:0]     out_md_valid;
   logic [CH*MW-1:0]  out_md;
   logic [CH*8-1:0]   out_usedw = '0;
   logic              buf_addr_full;
   logic [CH*32-1:0]  stat_pkts;
   logic [31:0]       stat_drops;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   int   out_cyc[$];
   exp_t mon_e;

   parse_pkt_disp_mc #(
      .DW(DW), .MW(MW), .CH(CH), .SEL_LSB(348), .FIFO_AW(8),
      .MD_AW(4), .OUT_THR(161), .IN_THR(160)
   ) dut (
      .clk(clk), .reset(reset),
      .pkt_head_valid(pkt_head_valid), .pkt_head(pkt_head),
      .pkt_payload_valid(pkt_payload_valid), .pkt_payload(pkt_payload),
      .pkt_metadata_valid(pkt_metadata_valid),
      .pkt_metadata(pkt_metadata),
      .out_data_valid(out_data_valid), .out_data(out_data),
      .out_md_valid(out_md_valid), .out_md(out_md),
      .out_usedw(out_usedw), .buf_addr_full(buf_addr_full),
      .stat_pkts(stat_pkts), .stat_drops(stat_drops)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            if (out_data_valid[i]) begin
               out_cyc.push_back(cyc);
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected ch%0d got %h want none",
                           i, out_data[i*DW +: DW]);
               end else begin
                  mon_e = sb.pop_front();
                  if (mon_e.ch != i || mon_e.w !== out_data[i*DW +: DW]) begin
                     errors++;
                     $display("FAIL word ch got %0d want %0d data got %h want %h",
                              i, mon_e.ch, out_data[i*DW +: DW], mon_e.w);
                  end else if (mon_e.md != out_md_valid[i]) begin
                     errors++;
                     $display("FAIL md_strobe ch%0d got %b want %b",
                              i, out_md_valid[i], mon_e.md);
                  end else if (mon_e.md && mon_e.m !== out_md[i*MW +: MW]) begin
                     errors++;
                     $display("FAIL md_data ch%0d got %h want %h",
                              i, out_md[i*MW +: MW], mon_e.m);
                  end
               end
            end else if (out_md_valid[i]) begin
               checks++;
               errors++;
               $display("FAIL md_no_data ch%0d got 1 want 0", i);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   function automatic logic [DW-1:0] mkw(input logic [2:0] t, input int id);
      logic [DW-1:0] w;
      w = '0;
      w[DW-1 -: 3] = t;
      w[31:0] = id;
      return w;
   endfunction

   function automatic logic [MW-1:0] mkmd(input bit d, input bit nb,
                                          input int s, input int id);
      logic [MW-1:0] m;
      m = '0;
      m[MW-1] = d;
      m[MW-4] = nb;
      m[348 +: 2] = s[1:0];
      m[31:0] = id;
      return m;
   endfunction

   task automatic chk(input string n, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, got, want);
      end
   endtask

   task automatic put_h(input logic [DW-1:0] w);
      pkt_head_valid = 1'b1;
      pkt_head = w;
      @(posedge clk); #1;
      pkt_head_valid = 1'b0;
   endtask

   task automatic put_p(input logic [DW-1:0] w);
      pkt_payload_valid = 1'b1;
      pkt_payload = w;
      @(posedge clk); #1;
      pkt_payload_valid = 1'b0;
   endtask

   task automatic put_m(input logic [MW-1:0] m);
      pkt_metadata_valid = 1'b1;
      pkt_metadata = m;
      @(posedge clk); #1;
      pkt_metadata_valid = 1'b0;
   endtask

   task automatic exp_w(input int ch, input logic [DW-1:0] w, input bit md,
                        input logic [MW-1:0] m);
      exp_t e;
      e.ch = ch; e.w = w; e.md = md; e.m = m;
      sb.push_back(e);
   endtask

   task automatic drain(input string n);
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk(n, 64'(sb.size()), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wait_outs(input string n, input int target);
      for (int i = 0; i < 100 && out_cyc.size() < target; i++) begin
         @(posedge clk); #1;
      end
      chk(n, 64'(out_cyc.size() >= target), 1);
   endtask

   logic [MW-1:0] m;
   int n0;
   int c0;

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dv", 64'(out_data_valid), 0);
      chk("rst_mv", 64'(out_md_valid), 0);
      chk("rst_data", 64'(out_data == '0), 1);
      chk("rst_md", 64'(out_md == '0), 1);
      chk("rst_full", 64'(buf_addr_full), 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // sel=2, 3-word header, no body
      m = mkmd(0, 1, 2, 100);
      put_h(mkw(3'b101, 11));
      put_h(mkw(3'b100, 12));
      put_h(mkw(3'b110, 13));
      exp_w(2, mkw(3'b101, 11), 0, '0);
      exp_w(2, mkw(3'b100, 12), 0, '0);
      exp_w(2, mkw(3'b110, 13), 1, m);
      n0 = out_cyc.size();
      put_m(m);
      c0 = cyc;
      drain("drain1");
      chk("lat1", 64'(out_cyc[n0] - c0), 3);
      chk("b2b1", 64'(out_cyc[n0+2] - out_cyc[n0]), 2);

      // sel=1, 2-word header + 4-word payload
      m = mkmd(0, 0, 1, 200);
      put_h(mkw(3'b101, 21));
      put_h(mkw(3'b110, 22));
      put_p(mkw(3'b100, 23));
      put_p(mkw(3'b100, 24));
      put_p(mkw(3'b100, 25));
      put_p(mkw(3'b110, 26));
      exp_w(1, mkw(3'b101, 21), 0, '0);
      exp_w(1, mkw(3'b100, 22), 0, '0);
      exp_w(1, mkw(3'b100, 23), 0, '0);
      exp_w(1, mkw(3'b100, 24), 0, '0);
      exp_w(1, mkw(3'b100, 25), 0, '0);
      exp_w(1, mkw(3'b110, 26), 1, m);
      n0 = out_cyc.size();
      put_m(m);
      drain("drain2");
      chk("cnt2", 64'(out_cyc.size() - n0), 6);
`ifdef PKT_DISP_STAT_EN
      chk("stat_pkts1", 64'(stat_pkts[63:32]), 1);
`else
      chk("stat_pkts0", 64'(stat_pkts == '0), 1);
`endif

      // discard, 5-word header
      put_h(mkw(3'b101, 31));
      put_h(mkw(3'b100, 32));
      put_h(mkw(3'b100, 33));
      put_h(mkw(3'b100, 34));
      put_h(mkw(3'b110, 35));
      n0 = out_cyc.size();
      put_m(mkmd(1, 1, 0, 300));
      repeat (20) @(posedge clk);
      #1;
      chk("disc_silent", 64'(out_cyc.size() - n0), 0);
      chk("disc_h_empty", 64'(dut.h_empty), 1);
`ifdef PKT_DISP_STAT_EN
      chk("stat_drops", 64'(stat_drops), 1);
`else
      chk("stat_drops0", 64'(stat_drops), 0);
`endif

      // backpressure on channel 3
      out_usedw[31:24] = 8'd200;
      m = mkmd(0, 1, 3, 400);
      put_h(mkw(3'b101, 41));
      put_h(mkw(3'b110, 42));
      exp_w(3, mkw(3'b101, 41), 0, '0);
      exp_w(3, mkw(3'b110, 42), 1, m);
      n0 = out_cyc.size();
      put_m(m);
      repeat (20) @(posedge clk);
      #1;
      chk("hold200", 64'(out_cyc.size() - n0), 0);
      out_usedw[31:24] = 8'd161;
      repeat (10) @(posedge clk);
      #1;
      chk("hold161", 64'(out_cyc.size() - n0), 0);
      out_usedw[31:24] = 8'd160;
      drain("drain4");
      chk("cnt4", 64'(out_cyc.size() - n0), 2);
      out_usedw[31:24] = 8'd0;

      // head underrun mid-packet
      m = mkmd(0, 1, 0, 500);
      put_h(mkw(3'b101, 51));
      put_h(mkw(3'b100, 52));
      exp_w(0, mkw(3'b101, 51), 0, '0);
      exp_w(0, mkw(3'b100, 52), 0, '0);
      exp_w(0, mkw(3'b100, 53), 0, '0);
      exp_w(0, mkw(3'b110, 54), 1, m);
      n0 = out_cyc.size();
      put_m(m);
      wait_outs("wait5", n0 + 2);
      @(posedge clk); #1;
      put_h(mkw(3'b100, 53));
      put_h(mkw(3'b110, 54));
      drain("drain5");
      chk("gap5a", 64'(out_cyc[n0+1] - out_cyc[n0]), 1);
      chk("gap5b", 64'(out_cyc[n0+2] - out_cyc[n0+1] - 1), 3);
      chk("gap5c", 64'(out_cyc[n0+3] - out_cyc[n0+2]), 1);

      // input threshold
      for (int i = 0; i < 159; i++) put_h(mkw(3'b100, 1000 + i));
      chk("full159", 64'(buf_addr_full), 0);
      put_h(mkw(3'b100, 2000));
      chk("full_early", 64'(buf_addr_full), 0);
      @(posedge clk); #1;
      chk("full160", 64'(buf_addr_full), 1);
      reset = 1'b0;
      #2;
      chk("full_rst", 64'(buf_addr_full), 0);
      chk("h_empty_rst", 64'(dut.h_empty), 1);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset mid-body
      m = mkmd(0, 0, 1, 600);
      put_h(mkw(3'b101, 61));
      put_h(mkw(3'b110, 62));
      put_p(mkw(3'b100, 63));
      put_p(mkw(3'b100, 64));
      exp_w(1, mkw(3'b101, 61), 0, '0);
      exp_w(1, mkw(3'b100, 62), 0, '0);
      exp_w(1, mkw(3'b100, 63), 0, '0);
      exp_w(1, mkw(3'b100, 64), 0, '0);
      n0 = out_cyc.size();
      put_m(m);
      wait_outs("wait6", n0 + 4);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #2;
      chk("rst6_dv", 64'(out_data_valid), 0);
      chk("rst6_mv", 64'(out_md_valid), 0);
      chk("rst6_data", 64'(out_data == '0), 1);
      chk("rst6_md", 64'(out_md == '0), 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // fresh packet after abort
      m = mkmd(0, 1, 2, 700);
      put_h(mkw(3'b101, 71));
      put_h(mkw(3'b110, 72));
      exp_w(2, mkw(3'b101, 71), 0, '0);
      exp_w(2, mkw(3'b110, 72), 1, m);
      n0 = out_cyc.size();
      put_m(m);
      c0 = cyc;
      drain("drain7");
      chk("lat7", 64'(out_cyc[n0] - c0), 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
